// File: rtl/fp_mul_pkg.sv
// Shared definitions for the 16-bit floating-point multiply sequencer:
// state encoding, default format parameters and operand field positions.
package fp_mul_pkg;

  // Default format: 1 sign bit, 8-bit exponent, 7-bit stored mantissa
  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 7;
  localparam int DEF_BIAS  = 127;

  // Operand field positions within the packed 16-bit word
  localparam int SIGN_BIT = 15;
  localparam int EXP_MSB  = 14;
  localparam int EXP_LSB  = 7;

  // State encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] NORM = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_MUL  = MUL,
    ST_NORM = NORM,
    ST_DONE = DONE
  } state_t;

  // True when an operand has both a zero exponent and a zero mantissa
  function automatic logic is_zero_operand(input logic [SIGN_BIT:0] v);
    return (v[EXP_MSB:0] == '0);
  endfunction

endpackage

// File: rtl/shift_add_mul_core.sv
// Iterative shift-add mantissa multiplier. A start pulse loads both
// mantissas (implicit 1 already attached) and clears the product; the core
// then retires one multiplier bit per cycle for MAN_W+1 cycles. 'done' is
// high during the final iteration so the controller can leave on that edge.
module shift_add_mul_core #(
  parameter int MAN_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAN_W:0]     a,
  input  logic [MAN_W:0]     b,
  output logic               done,
  output logic [2*MAN_W+1:0] p
);

  localparam int N     = MAN_W + 1;
  localparam int PW    = 2 * N;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAN_W);

  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [PW-1:0]    p_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  assign done = run_q && (cnt_q == LAST);
  assign p    = p_q;

  // Load operands on start, then add the shifted multiplicand for each set
  // multiplier bit, consuming the multiplier LSB-first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      a_q   <= a;
      b_q   <= b;
      p_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      if (b_q[0]) begin
        p_q <= p_q + ({{N{1'b0}}, a_q} << cnt_q);
      end
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_mul_sequencer.sv
// Sequencing controller for a 16-bit floating-point multiply. Accepts an
// operand pair over valid/ready, runs the shift-add mantissa multiply,
// normalises, applies the exponent bias and holds the packed result until
// the consumer takes it.
// Optional build macro FP_MUL_ZERO_BYPASS_EN: an operand with zero exponent
// and zero mantissa short-circuits straight to a signed zero result.
module fp_mul_sequencer
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  parameter int BIAS  = DEF_BIAS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIGN_BIT:0] x,
  input  logic [SIGN_BIT:0] y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIGN_BIT:0] z,
  output logic              ovf,
  output logic              unf,
  output logic              busy
);

  localparam int N   = MAN_W + 1;
  localparam int PW  = 2 * N;
  localparam int E_W = EXP_W + 2;
  localparam logic signed [E_W-1:0] E_MAX  = E_W'((1 << EXP_W) - 1);
  localparam logic signed [E_W-1:0] E_ZERO = '0;

  state_t state_q, state_d;

  logic                  sign_q;
  logic signed [E_W-1:0] expsum_q;
  logic                  sign_in;
  logic signed [E_W-1:0] expsum_in;

  logic [SIGN_BIT:0] z_q, z_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              out_valid_q, out_valid_d;

  logic              core_start;
  logic              core_done;
  logic [PW-1:0]     prod;

  logic signed [E_W-1:0] e_norm;
  logic [MAN_W-1:0]      man_norm;
  logic                  ovf_det;
  logic                  unf_det;
  logic                  unused_prod_bits;

`ifdef FP_MUL_ZERO_BYPASS_EN
  logic zero_op;
  assign zero_op = is_zero_operand(x) || is_zero_operand(y);
`endif

  assign sign_in   = x[SIGN_BIT] ^ y[SIGN_BIT];
  assign expsum_in = E_W'(x[EXP_MSB:EXP_LSB]) + E_W'(y[EXP_MSB:EXP_LSB]);

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

  shift_add_mul_core #(
    .MAN_W(MAN_W)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (core_start),
    .a     ({1'b1, x[MAN_W-1:0]}),
    .b     ({1'b1, y[MAN_W-1:0]}),
    .done  (core_done),
    .p     (prod)
  );

  // A product of two [1,2) mantissas lies in [1,4); the top bit picks which
  // window holds the fraction and whether the exponent gains one
  assign e_norm   = expsum_q - E_W'(BIAS) + E_W'(prod[PW-1]);
  assign man_norm = prod[PW-1] ? prod[PW-2 -: MAN_W] : prod[PW-3 -: MAN_W];
  assign ovf_det  = (e_norm >= E_MAX);
  assign unf_det  = (e_norm <= E_ZERO);

  // Bits below the kept mantissa are simply truncated
  assign unused_prod_bits = ^prod[PW-MAN_W-3:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture result sign and raw exponent sum when an operand pair is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q   <= 1'b0;
      expsum_q <= '0;
    end else if (state_q == ST_IDLE && in_valid) begin
      sign_q   <= sign_in;
      expsum_q <= expsum_in;
    end
  end

  // Result registers, held stable while waiting for the consumer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q         <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      z_q         <= z_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state, multiplier start and result packing
  always_comb begin
    state_d     = state_q;
    z_d         = z_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    out_valid_d = out_valid_q;
    core_start  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef FP_MUL_ZERO_BYPASS_EN
          if (zero_op) begin
            z_d         = {sign_in, {(EXP_W + MAN_W){1'b0}}};
            ovf_d       = 1'b0;
            unf_d       = 1'b0;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            core_start = 1'b1;
            state_d    = ST_MUL;
          end
`else
          core_start = 1'b1;
          state_d    = ST_MUL;
`endif
        end
      end
      ST_MUL: begin
        if (core_done) begin
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        if (ovf_det) begin
          z_d   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_d = 1'b1;
          unf_d = 1'b0;
        end else if (unf_det) begin
          z_d   = {sign_q, {(EXP_W + MAN_W){1'b0}}};
          ovf_d = 1'b0;
          unf_d = 1'b1;
        end else begin
          z_d   = {sign_q, e_norm[EXP_W-1:0], man_norm};
          ovf_d = 1'b0;
          unf_d = 1'b0;
        end
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/fp_mul_sequencer.md
Name: fp_mul_sequencer

Overview:
- Sequencing controller for 16-bit floating-point multiply: 1 sign bit, 8-bit exponent, 7-bit mantissa, implicit leading 1.
- Accepts operand pairs over a valid/ready handshake and runs an iterative shift-add mantissa multiply, one bit per cycle.
- Applies the PM15-style normalisation step, adds exponents with bias, then packs and holds the result until the consumer accepts it.
- Sits between the operand source and the result sink of the Lab4 FP multiplier path.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 7, stored mantissa width; the iteration count is MAN_W+1.
- BIAS, 127, exponent bias.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept an operand pair.
- x  in  16  operand X {sign, exp, man}.
- y  in  16  operand Y.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- z  out  16  packed product.
- ovf  out  1  exponent overflow, valid with out_valid.
- unf  out  1  exponent underflow, valid with out_valid.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, z=0, ovf=0, unf=0, busy=0, iteration counter=0, product register=0.
- States: IDLE, MUL, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch sign = x[15]^y[15], A={1,x[6:0]}, B={1,y[6:0]}, P=0, cnt=0, expsum = x[14:7]+y[14:7], computed 10-bit signed.
  - Go to MUL.
- MUL:
  - in_ready=0.
  - Each cycle: if B[0], P += A<<cnt; then B >>= 1 and cnt++.
  - After the cnt==7 iteration, go to NORM. This gives exactly 8 MUL cycles.
- NORM (one cycle):
  - If P[15]=1: man=P[14:8], e = expsum-BIAS+1.
  - Else: man=P[13:7], e = expsum-BIAS.
  - Rounding is truncation.
  - If e>=255: z={sign,8'hFF,7'h0}, ovf=1.
  - Else if e<=0: z={sign,15'h0}, unf=1.
  - Else: z={sign,e[7:0],man}, ovf=0, unf=0.
  - out_valid=1, go to DONE.
- DONE:
  - z, ovf, unf and out_valid are held stable while out_ready=0.
  - On out_ready=1: out_valid=0 and go to IDLE.
  - in_ready stays 0 in DONE; there is no overlap between results.
- Latency: out_valid rises on the 9th rising edge after the accept edge. Minimum throughput is one result per 11 cycles when out_ready is tied high.
- in_valid while busy is ignored and x/y are not sampled. The source must hold its pair until in_ready.
- rst asserted mid-operation aborts immediately to reset values. No partial result is emitted.
- Inputs with exponent 0 or 255 are treated as normal numbers; no NaN/Inf/denormal semantics, except as stated under ZERO_BYPASS_EN.

Optional Feature:
- Macro: FP_MUL_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, if either operand has exp==0 and man==0, the accept edge goes straight to DONE.
  - z={sign,15'h0}, ovf=0, unf=0.
  - out_valid rises on the accept edge itself, i.e. one cycle after acceptance, skipping MUL and NORM.
- Undefined: zero operands take the normal 9-cycle path with an implicit 1, so 0x0000 is treated as 2^-127.

Decomposition:
- Shared package fp_mul_pkg holds:
  - state encoding localparams IDLE=0, MUL=1, NORM=2, DONE=3;
  - EXP_W, MAN_W and BIAS defaults;
  - field-slice constants SIGN_BIT=15, EXP_MSB=14, EXP_LSB=7.
- One sub-module is natural: shift_add_mul_core.
  - Holds the A/B/P registers and the counter.
  - Ports: clk, rst, start, a[7:0], b[7:0], done, p[15:0].
- The top level owns the FSM, exponent path, normalisation and handshake.

Test Plan:
- Basic multiply: x=0x3F80, y=0x3F80 (1.0×1.0) -> z=0x3F80, ovf=0, unf=0; out_valid exactly 9 edges after accept.
- Normalisation: x=0x3FC0, y=0x3FC0 (1.5×1.5) exercises the P[15]=1 path -> z=0x4010 (2.25).
- Sign and backpressure: x=0xC000, y=0x4040 (-2×3) -> z=0xC0C0. Hold out_ready=0 for 5 cycles: z and out_valid stay stable and in_ready=0 throughout.
- Overflow and underflow:
  - x=0x7F00, y=0x4000 -> z=0x7F80, ovf=1.
  - x=0x0080, y=0x3F00 -> z=0x0000, unf=1.
- Reset mid-operation: assert rst 4 cycles into MUL -> next observed state is IDLE, in_ready=1, out_valid=0. A following 0x3F80×0x3F80 then completes correctly.
- FP_MUL_ZERO_BYPASS_EN: x=0x0000, y=0x4040 -> z=0x0000 with out_valid one cycle after accept. Without the macro, the same stimulus gives 9-cycle latency.
